// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM state encoding, default widths and
// the watchdog counter sizing helper.
package apb_pkg;

   localparam int APB_ADDR_W      = 32;
   localparam int APB_DATA_W      = 32;
   localparam int APB_TIMEOUT_DEF = 256;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_mst_state_t;

   // Counter width able to hold TIMEOUT; at least one bit so a disabled
   // watchdog (TIMEOUT = 0) still yields a legal vector.
   function automatic int wdog_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Bundles the command/response handshake and the APB master bus of the
// bridge. The master modport is the bridge's own view; the slave modport is
// the view of whatever sits around it (command source, response sink and
// the APB decoder).
interface apb_master_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;

   logic [ADDR_W-1:0] m_paddr;
   logic              m_pwrite;
   logic              m_psel;
   logic              m_penable;
   logic [DATA_W-1:0] m_pwdata;
   logic [DATA_W-1:0] m_prdata;
   logic              m_pready;
   logic              m_pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      input  m_prdata, m_pready, m_pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output m_paddr, m_pwrite, m_psel, m_penable, m_pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      output m_prdata, m_pready, m_pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  m_paddr, m_pwrite, m_psel, m_penable, m_pwdata
   );

endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding valid/ready to APB3 master bridge with an ACCESS-phase
// watchdog. Every output comes straight from a flop: the combinational
// process computes the next value of each output register together with
// the next state, and one clocked process loads them all.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = APB_TIMEOUT_DEF
) (
   input logic                 clk,
   input logic                 reset_n,
   apb_master_bridge_if.master bus
);

   localparam int               CNT_W    = wdog_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   apb_mst_state_t    state_q, state_d;
   logic [CNT_W-1:0]  wdog_q, wdog_d;

   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic              pwrite_q, pwrite_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;

   // Byte-lane bits of the command address never reach the bus.
   logic addr_lsb_unused;
   assign addr_lsb_unused = ^bus.cmd_addr[1:0];

   // Next state and next value of every output register.
   always_comb begin
      state_d       = state_q;
      wdog_d        = wdog_q;
      cmd_ready_d   = 1'b0;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      paddr_d       = paddr_q;
      pwrite_d      = pwrite_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwdata_d      = pwdata_q;

      case (state_q)
         IDLE: begin
            cmd_ready_d = 1'b1;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            // cmd_ready_q gates acceptance so the first idle cycle after
            // reset (cmd_ready still 0) never swallows a command.
            if (bus.cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               paddr_d     = {bus.cmd_addr[ADDR_W-1:2], 2'b00};
               pwrite_d    = bus.cmd_write;
               pwdata_d    = bus.cmd_wdata;
               psel_d      = 1'b1;
               wdog_d      = '0;
               state_d     = SETUP;
            end
         end

         SETUP: begin
            psel_d    = 1'b1;
            penable_d = 1'b1;
            state_d   = ACCESS;
         end

         ACCESS: begin
            if (wdog_q != CNT_MAX) begin
               wdog_d = wdog_q + 1'b1;
            end
            // A ready slave takes priority over a watchdog expiring in
            // the same cycle.
            if (bus.m_pready) begin
               rsp_rdata_d   = pwrite_q ? '0 : bus.m_prdata;
               rsp_err_d     = bus.m_pslverr;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               state_d       = RESP;
            end else if (TIMEOUT != 0 && wdog_q == CNT_LAST) begin
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               state_d       = RESP;
            end
         end

         RESP: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            if (bus.rsp_ready && rsp_valid_q) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, watchdog and output registers; reset clears everything so an
   // in-flight transfer and its pending response are dropped.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         wdog_q        <= '0;
         cmd_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         paddr_q       <= '0;
         pwrite_q      <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwdata_q      <= '0;
      end else begin
         state_q       <= state_d;
         wdog_q        <= wdog_d;
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         paddr_q       <= paddr_d;
         pwrite_q      <= pwrite_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwdata_q      <= pwdata_d;
      end
   end

   assign bus.cmd_ready   = cmd_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.m_paddr     = paddr_q;
   assign bus.m_pwrite    = pwrite_q;
   assign bus.m_psel      = psel_q;
   assign bus.m_penable   = penable_q;
   assign bus.m_pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed vector table, randomized
// transactions against a transaction-level model, and a backpressure plus
// mid-transfer reset sequence.
module tb_apb_master_bridge;

   localparam int TMO = 8;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   apb_master_bridge #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(TMO)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] prdata;
      int          waits;      // ACCESS cycles before pready; >= TMO means never
      logic        slverr;
      int          rsp_delay;  // extra cycles with rsp_ready low
      logic        hold_ready; // rsp_ready kept high the whole time
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_to;
      int          exp_acc;    // ACCESS cycles expected
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] prdata, input int waits, input logic slverr,
                               input int delay, input logic hold);
      vec_t v;
      v.write      = wr;
      v.addr       = addr;
      v.wdata      = wdata;
      v.prdata     = prdata;
      v.waits      = waits;
      v.slverr     = slverr;
      v.rsp_delay  = delay;
      v.hold_ready = hold;
      v.exp_rdata  = '0;
      v.exp_err    = 1'b0;
      v.exp_to     = 1'b0;
      v.exp_acc    = 0;
      return v;
   endfunction

   // Transaction-level reference: the slave answers after 'waits' stalled
   // ACCESS cycles unless the watchdog runs out first.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      if (v.waits < TMO) begin
         r.exp_rdata = v.write ? 32'h0 : v.prdata;
         r.exp_err   = v.slverr;
         r.exp_to    = 1'b0;
         r.exp_acc   = v.waits + 1;
      end else begin
         r.exp_rdata = 32'h0;
         r.exp_err   = 1'b1;
         r.exp_to    = 1'b1;
         r.exp_acc   = TMO;
      end
      return r;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, " cmd_ready"},   bus.cmd_ready,   0);
      check({tag, " rsp_valid"},   bus.rsp_valid,   0);
      check({tag, " rsp_rdata"},   bus.rsp_rdata,   0);
      check({tag, " rsp_err"},     bus.rsp_err,     0);
      check({tag, " rsp_timeout"}, bus.rsp_timeout, 0);
      check({tag, " m_paddr"},     bus.m_paddr,     0);
      check({tag, " m_pwrite"},    bus.m_pwrite,    0);
      check({tag, " m_psel"},      bus.m_psel,      0);
      check({tag, " m_penable"},   bus.m_penable,   0);
      check({tag, " m_pwdata"},    bus.m_pwdata,    0);
   endtask

   task automatic run_txn(input vec_t v, input string tag);
      logic [31:0] pa;
      int          acc;
      bit          done;
      pa   = v.addr & 32'hFFFF_FFFC;
      acc  = 0;
      done = 0;

      @(negedge clk);
      check({tag, " idle cmd_ready"}, bus.cmd_ready, 1);
      check({tag, " idle rsp_valid"}, bus.rsp_valid, 0);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = v.write;
      bus.cmd_addr  = v.addr;
      bus.cmd_wdata = v.wdata;
      bus.rsp_ready = v.hold_ready;
      bus.m_pready  = 1'b0;

      @(negedge clk);
      check({tag, " setup psel"},      bus.m_psel,    1);
      check({tag, " setup penable"},   bus.m_penable, 0);
      check({tag, " setup cmd_ready"}, bus.cmd_ready, 0);
      check({tag, " setup paddr"},     bus.m_paddr,   pa);
      check({tag, " setup pwrite"},    bus.m_pwrite,  v.write);
      check({tag, " setup pwdata"},    bus.m_pwdata,  v.wdata);
      // Garbage on cmd_* and on pready during SETUP must not matter.
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_write = 1'($urandom_range(0, 1));
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
      bus.m_pready  = 1'($urandom_range(0, 1));
      bus.m_prdata  = $urandom;
      bus.m_pslverr = 1'($urandom_range(0, 1));

      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (bus.m_psel && bus.m_penable) begin
            check({tag, " access paddr"},     bus.m_paddr,   pa);
            check({tag, " access pwdata"},    bus.m_pwdata,  v.wdata);
            check({tag, " access pwrite"},    bus.m_pwrite,  v.write);
            check({tag, " access rsp_valid"}, bus.rsp_valid, 0);
            bus.m_pready  = (acc == v.waits);
            bus.m_prdata  = bus.m_pready ? v.prdata : $urandom;
            bus.m_pslverr = bus.m_pready ? v.slverr : 1'($urandom_range(0, 1));
            acc++;
         end else begin
            done = 1;
         end
      end
      if (!done) check({tag, " access bound"}, 0, 1);
      bus.m_pready  = 1'b0;
      bus.m_pslverr = 1'b0;

      check({tag, " access cycles"},   acc,             v.exp_acc);
      check({tag, " rsp_valid"},       bus.rsp_valid,   1);
      check({tag, " resp psel"},       bus.m_psel,      0);
      check({tag, " resp penable"},    bus.m_penable,   0);
      check({tag, " resp cmd_ready"},  bus.cmd_ready,   0);
      check({tag, " rsp_rdata"},       bus.rsp_rdata,   v.exp_rdata);
      check({tag, " rsp_err"},         bus.rsp_err,     v.exp_err);
      check({tag, " rsp_timeout"},     bus.rsp_timeout, v.exp_to);
      check({tag, " resp paddr hold"}, bus.m_paddr,     pa);

      if (!v.hold_ready) begin
         for (int d = 0; d < v.rsp_delay; d++) begin
            @(negedge clk);
            check({tag, " bp rsp_valid"},   bus.rsp_valid,   1);
            check({tag, " bp rsp_rdata"},   bus.rsp_rdata,   v.exp_rdata);
            check({tag, " bp rsp_err"},     bus.rsp_err,     v.exp_err);
            check({tag, " bp rsp_timeout"}, bus.rsp_timeout, v.exp_to);
            check({tag, " bp cmd_ready"},   bus.cmd_ready,   0);
         end
         bus.rsp_ready = 1'b1;
      end

      @(negedge clk);
      check({tag, " done rsp_valid"}, bus.rsp_valid, 0);
      check({tag, " done cmd_ready"}, bus.cmd_ready, 1);
      check({tag, " done psel"},      bus.m_psel,    0);
      bus.cmd_valid = 1'b0;
      if (!v.hold_ready) bus.rsp_ready = 1'b0;
   endtask

   vec_t vecs[$];
   vec_t v;

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;
      bus.m_prdata  = '0;
      bus.m_pready  = 1'b0;
      bus.m_pslverr = 1'b0;

      // Directed vectors with hand-derived expectations.
      v = mk(1'b0, 32'h0000_0404, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 0, 1'b0);
      v.exp_rdata = 32'hCAFE_F00D; v.exp_err = 0; v.exp_to = 0; v.exp_acc = 1;
      vecs.push_back(v);
      v = mk(1'b1, 32'h0000_0C00, 32'h1234_5678, 32'hDEAD_BEEF, 3, 1'b0, 0, 1'b0);
      v.exp_rdata = 32'h0; v.exp_err = 0; v.exp_to = 0; v.exp_acc = 4;
      vecs.push_back(v);
      v = mk(1'b0, 32'h0000_0010, 32'h0, 32'h5555_AAAA, 0, 1'b1, 1, 1'b0);
      v.exp_rdata = 32'h5555_AAAA; v.exp_err = 1; v.exp_to = 0; v.exp_acc = 1;
      vecs.push_back(v);
      v = mk(1'b0, 32'h0000_0020, 32'h0, 32'h1111_2222, 100, 1'b0, 0, 1'b0);
      v.exp_rdata = 32'h0; v.exp_err = 1; v.exp_to = 1; v.exp_acc = 8;
      vecs.push_back(v);
      v = mk(1'b0, 32'h0000_0030, 32'h0, 32'h7777_8888, 7, 1'b0, 0, 1'b1);
      v.exp_rdata = 32'h7777_8888; v.exp_err = 0; v.exp_to = 0; v.exp_acc = 8;
      vecs.push_back(v);
      v = mk(1'b1, 32'h0000_1237, 32'hA5A5_0F0F, 32'h0BAD_0BAD, 1, 1'b0, 5, 1'b0);
      v.exp_rdata = 32'h0; v.exp_err = 0; v.exp_to = 0; v.exp_acc = 2;
      vecs.push_back(v);

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);
      check("post-reset cmd_ready", bus.cmd_ready, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
      end

      // Randomized transactions against the reference model.
      for (int i = 0; i < 40; i++) begin
         v = mk(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                $urandom_range(0, TMO + 3), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         run_txn(model(v), $sformatf("rnd%0d", i));
      end

      // Reset during ACCESS: outputs clear and the response never appears.
      begin
         bit seen_rsp;
         seen_rsp = 0;
         @(negedge clk);
         check("rst idle cmd_ready", bus.cmd_ready, 1);
         bus.cmd_valid = 1'b1;
         bus.cmd_write = 1'b0;
         bus.cmd_addr  = 32'h0000_2000;
         bus.rsp_ready = 1'b1;
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         bus.m_pready  = 1'b0;
         @(negedge clk);
         check("rst access penable", bus.m_penable, 1);
         reset_n       = 1'b0;
         bus.m_pready  = 1'b1;
         bus.m_prdata  = 32'hFFFF_0000;
         @(negedge clk);
         check_all_zero("midrst");
         reset_n      = 1'b1;
         bus.m_pready = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen_rsp = 1;
         end
         check("midrst no response", seen_rsp, 0);
         check("midrst cmd_ready",   bus.cmd_ready, 1);
         check("midrst psel",        bus.m_psel,    0);
      end

      // Bridge still works after the abandoned transfer.
      v = mk(1'b0, 32'h0000_0404, 32'h0, 32'h0123_4567, 0, 1'b0, 0, 1'b0);
      run_txn(model(v), "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit so a stuck DUT cannot hang the run.
   initial begin
      #500000;
      $display("FAIL global timeout: got hang, expected completion");
      $fatal(1, "timeout");
   end

endmodule
